// File: rtl/ocd_frame_loader.sv
// On-chip-debug frame engine: parses sync'd, CRC-16 protected frames from a
// byte UART, buffers burst writes until the CRC checks, drains them to program
// RAM, drives CPU reset/start, and returns a one-byte status reply.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for first sync byte 0x5A
// SYNC1   | got 0x5A, waiting for 0xA5
// CMD     | waiting for command byte (CRC restarted)
// ADDR    | shifting in AB address bytes, MSB first
// LEN     | length byte; command and length validated here
// DATA    | LEN*WB payload bytes assembled into the burst buffer
// CRC     | two received CRC bytes, MSB first
// CHECK   | one cycle: compare CRC, act on START/RESET
// DRAIN   | one buffered word written to RAM per cycle
// REPLY   | status byte offered on tx until accepted
module ocd_frame_loader #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [WORD_WIDTH-1:0] mem_wr_data,
  output logic                  cpu_reset,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] cpu_start_addr,
  output logic                  busy,
  output logic                  uart_tx_sel_ocd1_cpu0
);

  localparam int WB    = WORD_WIDTH / 8;
  localparam int AB    = (ADDR_WIDTH + 7) / 8;
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_START = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'h04;

  localparam logic [3:0] ST_OK      = 4'h0;
  localparam logic [3:0] ST_CRC     = 4'h1;
  localparam logic [3:0] ST_BADCMD  = 4'h2;
  localparam logic [3:0] ST_BADLEN  = 4'h3;
  localparam logic [3:0] ST_TIMEOUT = 4'h4;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC1, S_CMD, S_ADDR, S_LEN, S_DATA, S_CRC, S_CHECK, S_DRAIN, S_REPLY
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [15:0]           crc_q, crc_d;
  logic [15:0]           rxcrc_q, rxcrc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            wb_cnt_q, wb_cnt_d;
  logic [7:0]            widx_q, widx_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [3:0]            status_q, status_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_start_q, cpu_start_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic                  sel_q, sel_d;

  logic [WORD_WIDTH-1:0] buf_q [MAX_WORDS];
  logic                  buf_we;
  logic                  in_frame;
  logic                  timeout;
  logic                  cmd_known;
  logic [15:0]           crc_next;

  // MSB-first CRC-16/CCITT update for one byte
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_next  = crc16_byte(crc_q, rx_data);
  assign in_frame  = (state_q == S_SYNC1) || (state_q == S_CMD) || (state_q == S_ADDR) ||
                     (state_q == S_LEN)   || (state_q == S_DATA) || (state_q == S_CRC);
  // Timer is reloaded by each byte, so it only expires across a silent gap.
  assign timeout   = in_frame && !rx_valid && (tmr_q == '0);
  assign cmd_known = (cmd_q == CMD_WRITE) || (cmd_q == CMD_START) || (cmd_q == CMD_RESET);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      crc_q        <= 16'hFFFF;
      rxcrc_q      <= '0;
      cnt_q        <= '0;
      wb_cnt_q     <= '0;
      widx_q       <= '0;
      word_q       <= '0;
      status_q     <= '0;
      tmr_q        <= '0;
      cpu_reset_q  <= 1'b0;
      cpu_start_q  <= 1'b0;
      start_addr_q <= '0;
      sel_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      crc_q        <= crc_d;
      rxcrc_q      <= rxcrc_d;
      cnt_q        <= cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      widx_q       <= widx_d;
      word_q       <= word_d;
      status_q     <= status_d;
      tmr_q        <= tmr_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_start_q  <= cpu_start_d;
      start_addr_q <= start_addr_d;
      sel_q        <= sel_d;
    end
  end

  // Burst buffer; a word is stored as its last byte arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_WORDS; i++) buf_q[i] <= '0;
    end else if (buf_we) begin
      buf_q[widx_q[IDX_W-1:0]] <= word_d;
    end
  end

  // Next-state, frame parsing and control actions
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    len_d        = len_q;
    crc_d        = crc_q;
    rxcrc_d      = rxcrc_q;
    cnt_d        = cnt_q;
    wb_cnt_d     = wb_cnt_q;
    widx_d       = widx_q;
    word_d       = word_q;
    status_d     = status_q;
    cpu_reset_d  = cpu_reset_q;
    cpu_start_d  = 1'b0;
    start_addr_d = start_addr_q;
    sel_d        = sel_q;
    buf_we       = 1'b0;

    tmr_d = tmr_q;
    if (rx_valid && (state_q == S_IDLE || in_frame)) tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
    else if (in_frame && tmr_q != '0)                tmr_d = tmr_q - 1'b1;

    if (timeout) begin
      status_d = ST_TIMEOUT;
      state_d  = S_REPLY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_data == 8'h5A) begin
            cmd_d   = '0;
            state_d = S_SYNC1;
          end
        end
        S_SYNC1: begin
          if (rx_valid) begin
            if (rx_data == 8'hA5) begin
              crc_d   = 16'hFFFF;
              state_d = S_CMD;
            end else if (rx_data != 8'h5A) begin
              state_d = S_IDLE;
            end
          end
        end
        S_CMD: begin
          if (rx_valid) begin
            cmd_d   = rx_data;
            crc_d   = crc_next;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_d = (addr_q << 8) | ADDR_WIDTH'(rx_data);
            crc_d  = crc_next;
            if (cnt_q == 8'(AB - 1)) state_d = S_LEN;
            else                     cnt_d   = cnt_q + 8'd1;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            len_d    = rx_data;
            crc_d    = crc_next;
            cnt_d    = '0;
            wb_cnt_d = '0;
            widx_d   = '0;
            if (!cmd_known) begin
              status_d = ST_BADCMD;
              state_d  = S_REPLY;
            end else if (cmd_q == CMD_WRITE) begin
              if (rx_data == 8'd0 || rx_data > 8'(MAX_WORDS)) begin
                status_d = ST_BADLEN;
                state_d  = S_REPLY;
              end else begin
                state_d = S_DATA;
              end
            end else if (rx_data != 8'd0) begin
              status_d = ST_BADLEN;
              state_d  = S_REPLY;
            end else begin
              state_d = S_CRC;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            crc_d  = crc_next;
            word_d = (word_q << 8) | WORD_WIDTH'(rx_data);
            if (wb_cnt_q == 8'(WB - 1)) begin
              buf_we   = 1'b1;
              wb_cnt_d = '0;
              if (widx_q == len_q - 8'd1) begin
                cnt_d   = '0;
                state_d = S_CRC;
              end else begin
                widx_d = widx_q + 8'd1;
              end
            end else begin
              wb_cnt_d = wb_cnt_q + 8'd1;
            end
          end
        end
        S_CRC: begin
          if (rx_valid) begin
            rxcrc_d = {rxcrc_q[7:0], rx_data};
            if (cnt_q == 8'd1) state_d = S_CHECK;
            else               cnt_d   = 8'd1;
          end
        end
        S_CHECK: begin
          cnt_d = '0;
          if (crc_q != rxcrc_q) begin
            status_d = ST_CRC;
            state_d  = S_REPLY;
          end else if (cmd_q == CMD_WRITE) begin
            state_d = S_DRAIN;
          end else begin
            status_d = ST_OK;
            state_d  = S_REPLY;
            if (cmd_q == CMD_START) begin
              cpu_reset_d  = 1'b0;
              cpu_start_d  = 1'b1;
              start_addr_d = addr_q;
            end else begin
              cpu_reset_d = 1'b1;
              sel_d       = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == len_q - 8'd1) begin
            status_d = ST_OK;
            state_d  = S_REPLY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_REPLY: begin
          if (tx_ready) begin
            // A successful START hands the UART to the CPU once its reply is gone.
            if (cmd_q == CMD_START && status_q == ST_OK) sel_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign mem_wr_en             = (state_q == S_DRAIN);
  assign mem_wr_addr           = mem_wr_en ? addr_q + ADDR_WIDTH'(cnt_q) : '0;
  assign mem_wr_data           = mem_wr_en ? buf_q[cnt_q[IDX_W-1:0]] : '0;
  assign tx_valid              = (state_q == S_REPLY);
  assign tx_data               = {cmd_q[3:0], status_q};
  assign cpu_reset             = cpu_reset_q;
  assign cpu_start             = cpu_start_q;
  assign cpu_start_addr        = start_addr_q;
  assign busy                  = (state_q != S_IDLE);
  assign uart_tx_sel_ocd1_cpu0 = sel_q;

endmodule

// File: tb/tb_ocd_frame_loader.sv
// Scoreboard bench for ocd_frame_loader: expected RAM writes and reply bytes
// are queued as frames are built and checked as the DUT produces them.
module tb_ocd_frame_loader;

  localparam int WW = 32;
  localparam int AW = 16;
  localparam int MW = 16;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [WW-1:0] mem_wr_data;
  logic          cpu_reset;
  logic          cpu_start;
  logic [AW-1:0] cpu_start_addr;
  logic          busy;
  logic          uart_tx_sel_ocd1_cpu0;

  ocd_frame_loader #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAX_WORDS(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start), .cpu_start_addr(cpu_start_addr),
    .busy(busy), .uart_tx_sel_ocd1_cpu0(uart_tx_sel_ocd1_cpu0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rp_q[$];
  logic [7:0] fr[$];
  logic [WW-1:0] wbuf [MW+1];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference CRC: XOR byte into the top, then shift eight times.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic build(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] len,
                       input int nw, input logic flip);
    logic [15:0] c;
    logic [7:0]  body[$];
    body.delete();
    body.push_back(cmd);
    body.push_back(addr[15:8]);
    body.push_back(addr[7:0]);
    body.push_back(len);
    for (int w = 0; w < nw; w++)
      for (int b = WW / 8 - 1; b >= 0; b--) body.push_back(wbuf[w][b*8 +: 8]);
    c = 16'hFFFF;
    foreach (body[i]) c = crc_model(c, body[i]);
    if (flip) body[6] = body[6] ^ 8'h08;
    fr.delete();
    fr.push_back(8'h5A);
    fr.push_back(8'hA5);
    foreach (body[i]) fr.push_back(body[i]);
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int nbytes);
    int n;
    n = (nbytes < 0) ? fr.size() : nbytes;
    for (int i = 0; i < n; i++) send_byte(fr[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_reply(input string tag);
    logic got;
    got = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk(tag, 32'(got), 32'd1);
  endtask

  // Output monitor: pops scoreboard entries as writes and replies appear
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(mem_wr_en), 32'd0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", 32'(mem_wr_addr), 32'(e.a));
          chk("wr_data", mem_wr_data, e.d);
        end
      end
      if (tx_valid && tx_ready) begin
        if (rp_q.size() == 0) chk("tx_unexpected", 32'(tx_valid), 32'd0);
        else chk("tx_data", 32'(tx_data), 32'(rp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
    chk("rst_mem_addr", 32'(mem_wr_addr), 0);
    chk("rst_mem_data", mem_wr_data, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 0);
    chk("rst_cpu_start", 32'(cpu_start), 0);
    chk("rst_start_addr", 32'(cpu_start_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_uart_sel", 32'(uart_tx_sel_ocd1_cpu0), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(2);

    // Good WRITE burst, with reply latency checks
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'h55667788;
    build(8'h01, 16'h0010, 8'd2, 2, 1'b0);
    wr_q.push_back('{a: 16'h0010, d: 32'h11223344});
    wr_q.push_back('{a: 16'h0011, d: 32'h55667788});
    rp_q.push_back(8'h10);
    send_frame(-1);
    chk("check_busy", 32'(busy), 1);
    chk("check_no_wr", 32'(mem_wr_en), 0);
    tick(1);
    chk("drain_start", 32'(mem_wr_en), 1);
    tick(2);
    chk("reply_lat", 32'(tx_valid), 1);
    wait_reply("rp_write");
    chk("wr_left_a", wr_q.size(), 0);

    // Same frame with a corrupted payload bit
    build(8'h01, 16'h0010, 8'd2, 2, 1'b1);
    rp_q.push_back(8'h11);
    send_frame(-1);
    wait_reply("rp_crc_err");

    // Address wrap
    wbuf[0] = 32'hA5A50001;
    wbuf[1] = 32'h0BADF00D;
    build(8'h01, 16'hFFFF, 8'd2, 2, 1'b0);
    wr_q.push_back('{a: 16'hFFFF, d: 32'hA5A50001});
    wr_q.push_back('{a: 16'h0000, d: 32'h0BADF00D});
    rp_q.push_back(8'h10);
    send_frame(-1);
    wait_reply("rp_wrap");
    chk("wr_left_wrap", wr_q.size(), 0);

    // RESET then START
    build(8'h04, 16'h0000, 8'd0, 0, 1'b0);
    rp_q.push_back(8'h40);
    send_frame(-1);
    tick(1);
    chk("reset_cpu_reset", 32'(cpu_reset), 1);
    chk("reset_uart_sel", 32'(uart_tx_sel_ocd1_cpu0), 1);
    wait_reply("rp_reset");

    build(8'h03, 16'h0200, 8'd0, 0, 1'b0);
    rp_q.push_back(8'h30);
    send_frame(-1);
    chk("start_pre", 32'(cpu_start), 0);
    tick(1);
    chk("start_pulse", 32'(cpu_start), 1);
    chk("start_addr", 32'(cpu_start_addr), 32'h0200);
    chk("start_cpu_reset", 32'(cpu_reset), 0);
    chk("start_sel_hold", 32'(uart_tx_sel_ocd1_cpu0), 1);
    tick(1);
    chk("start_pulse_end", 32'(cpu_start), 0);
    wait_reply("rp_start");
    chk("start_sel_fall", 32'(uart_tx_sel_ocd1_cpu0), 0);

    // Rejected frames
    build(8'h07, 16'h0000, 8'd0, 0, 1'b0);
    rp_q.push_back(8'h72);
    send_frame(-1);
    wait_reply("rp_badcmd");
    build(8'h01, 16'h0010, 8'd0, 0, 1'b0);
    rp_q.push_back(8'h13);
    send_frame(-1);
    wait_reply("rp_len0");
    build(8'h01, 16'h0010, 8'(MW + 1), 0, 1'b0);
    rp_q.push_back(8'h13);
    send_frame(-1);
    wait_reply("rp_len_over");

    // Inter-byte timeout after 3 payload bytes, reply held while tx_ready low
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'hCAFEF00D;
    build(8'h01, 16'h0010, 8'd2, 2, 1'b0);
    rp_q.push_back(8'h14);
    send_frame(9);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_latency", lat, TO + 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("to_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h14});
    end
    @(posedge clk);
    #1;
    wait_reply("rp_timeout");

    // Reset asserted during DRAIN after the first word
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h0100_0000 + i;
    build(8'h01, 16'h0040, 8'd4, 4, 1'b0);
    wr_q.push_back('{a: 16'h0040, d: 32'h0100_0000});
    send_frame(-1);
    tick(1);
    tick(1);
    reset_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(mem_wr_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_uart_sel", 32'(uart_tx_sel_ocd1_cpu0), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(10);
    chk("abort_no_reply", 32'(tx_valid), 0);
    chk("wr_left_end", wr_q.size(), 0);
    chk("rp_left_end", rp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
